first_fsm: RTL and testbench



---
 rtl/first_fsm.sv | 58 +++++
 tb/tb_first_fsm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/first_fsm.sv
// Two-state Moore toggle tracker: in=0 flips A<->B, in=1 holds; out is high in state B.
// Latency: 1 cycle from a sampled in to the matching out; out decodes from the state register only.
// Backpressure: none; a new in value is accepted on every rising clk edge.
//
// Ports:
//   clk     - single clock, all state updates on its rising edge
//   areset  - synchronous active-high reset, forces RESET_STATE (dominates in)
//   in      - control input: 0 = toggle state, 1 = hold state
//   out     - 1 while in state B, 0 while in state A
module first_fsm #(
  parameter logic RESET_STATE = 1'b1  // 1'b1 = B, 1'b0 = A
) (
  input  logic clk,
  input  logic areset,
  input  logic in,
  output logic out
);

  typedef enum logic {
    A = 1'b0,
    B = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  // State register. The reset name carries an "a" prefix for historical
  // reasons only; it is sampled on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (areset) begin
      state <= state_t'(RESET_STATE);
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore output decode. out depends on state alone so that
  // in has no combinational path to out.
  always_comb begin
    next_state = state;
    out        = 1'b0;
    case (state)
      A: begin
        next_state = in ? A : B;
        out        = 1'b0;
      end
      B: begin
        next_state = in ? B : A;
        out        = 1'b1;
      end
      default: begin
        next_state = state;
        out        = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_first_fsm.sv
module tb_first_fsm;

  logic clk;
  logic areset;
  logic in_s;
  logic out_b;   // default instance, resets to B
  logic out_a;   // RESET_STATE = A instance

  int total;
  int bad;

  // Scoreboard: expected outputs pushed when stimulus is driven, popped after the edge.
  logic exp_q_b[$];
  logic exp_q_a[$];

  // Reference state for each instance (1 = B).
  logic model_b;
  logic model_a;

  logic exp_b;
  logic exp_a;

  first_fsm dut_b (
    .clk    (clk),
    .areset (areset),
    .in     (in_s),
    .out    (out_b)
  );

  first_fsm #(.RESET_STATE(1'b0)) dut_a (
    .clk    (clk),
    .areset (areset),
    .in     (in_s),
    .out    (out_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus on the falling edge, predict, then advance past the
  // next rising edge so outputs can be sampled away from it.
  task automatic step(input logic r, input logic i);
    @(negedge clk);
    areset = r;
    in_s   = i;
    if (r) begin
      model_b = 1'b1;
      model_a = 1'b0;
    end else if (!i) begin
      model_b = ~model_b;
      model_a = ~model_a;
    end
    exp_q_b.push_back(model_b);
    exp_q_a.push_back(model_a);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      exp_b = exp_q_b.pop_front();
      exp_a = exp_q_a.pop_front();
      total += 2;
      if (out_b !== exp_b) begin
        bad++;
        $display("FAIL reset_b edge %0d: out=%b expected %b", k, out_b, exp_b);
      end
      if (out_a !== exp_a) begin
        bad++;
        $display("FAIL reset_a edge %0d: out=%b expected %b", k, out_a, exp_a);
      end
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1);
      exp_b = exp_q_b.pop_front();
      exp_a = exp_q_a.pop_front();
      total += 2;
      if (out_b !== exp_b) begin
        bad++;
        $display("FAIL hold_b edge %0d: out=%b expected %b", k, out_b, exp_b);
      end
      if (out_a !== exp_a) begin
        bad++;
        $display("FAIL hold_a edge %0d: out=%b expected %b", k, out_a, exp_a);
      end
    end
  endtask

  task automatic test_toggle_hold();
    logic [4:0] pat;
    logic [4:0] want;
    pat  = 5'b01110;  // applied LSB first: 0,1,1,1,0
    want = 5'b10000;  // out_b from B: 0,0,0,0,1
    for (int k = 0; k < 5; k++) begin
      step(1'b0, pat[k]);
      exp_b = exp_q_b.pop_front();
      exp_a = exp_q_a.pop_front();
      total += 3;
      if (out_b !== exp_b) begin
        bad++;
        $display("FAIL toggle_hold_b edge %0d: out=%b expected %b", k, out_b, exp_b);
      end
      if (out_b !== want[k]) begin
        bad++;
        $display("FAIL toggle_hold_seq edge %0d: out=%b expected %b", k, out_b, want[k]);
      end
      if (out_a !== exp_a) begin
        bad++;
        $display("FAIL toggle_hold_a edge %0d: out=%b expected %b", k, out_a, exp_a);
      end
    end
  endtask

  task automatic test_alternate();
    logic [4:0] want;
    want = 5'b01010;  // LSB first: 0,1,0,1,0
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      exp_b = exp_q_b.pop_front();
      exp_a = exp_q_a.pop_front();
      total += 3;
      if (out_b !== exp_b) begin
        bad++;
        $display("FAIL alternate_b edge %0d: out=%b expected %b", k, out_b, exp_b);
      end
      if (out_b !== want[k]) begin
        bad++;
        $display("FAIL alternate_seq edge %0d: out=%b expected %b", k, out_b, want[k]);
      end
      if (out_a !== exp_a) begin
        bad++;
        $display("FAIL alternate_a edge %0d: out=%b expected %b", k, out_a, exp_a);
      end
    end
  endtask

  // Starts in A (after test_alternate). Reset raised mid-cycle must not reach out
  // before the edge; then reset from B as well.
  task automatic test_mid_reset();
    @(negedge clk);
    areset = 1'b1;
    in_s   = 1'b0;
    #2;
    total++;
    if (out_b !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_before_edge: out=%b expected 0", out_b);
    end
    // Complete that reset cycle through the scoreboard.
    model_b = 1'b1;
    model_a = 1'b0;
    exp_q_b.push_back(model_b);
    exp_q_a.push_back(model_a);
    @(posedge clk);
    #1;
    exp_b = exp_q_b.pop_front();
    exp_a = exp_q_a.pop_front();
    total += 2;
    if (out_b !== exp_b) begin
      bad++;
      $display("FAIL mid_reset_edge_b: out=%b expected %b", out_b, exp_b);
    end
    if (out_a !== exp_a) begin
      bad++;
      $display("FAIL mid_reset_edge_a: out=%b expected %b", out_a, exp_a);
    end
    // Drop reset, toggle, then reset again from A for dut_b / B for dut_a.
    for (int k = 0; k < 2; k++) begin
      step(k == 1, 1'b0);
      exp_b = exp_q_b.pop_front();
      exp_a = exp_q_a.pop_front();
      total += 2;
      if (out_b !== exp_b) begin
        bad++;
        $display("FAIL mid_reset_after_b step %0d: out=%b expected %b", k, out_b, exp_b);
      end
      if (out_a !== exp_a) begin
        bad++;
        $display("FAIL mid_reset_after_a step %0d: out=%b expected %b", k, out_a, exp_a);
      end
    end
  endtask

  // dut_a resets to A, then toggles to B; reset held long ignores in.
  task automatic test_reset_state_a();
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      step(1'b1, 1'b1);
      else if (k == 1) step(1'b0, 1'b0);
      else             step(1'b1, 1'($urandom_range(0, 1)));
      exp_b = exp_q_b.pop_front();
      exp_a = exp_q_a.pop_front();
      total += 2;
      if (out_a !== exp_a) begin
        bad++;
        $display("FAIL reset_state_a step %0d: out=%b expected %b", k, out_a, exp_a);
      end
      if (out_b !== exp_b) begin
        bad++;
        $display("FAIL reset_state_b step %0d: out=%b expected %b", k, out_b, exp_b);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
      exp_b = exp_q_b.pop_front();
      exp_a = exp_q_a.pop_front();
      total += 2;
      if (out_b !== exp_b) begin
        bad++;
        $display("FAIL random_b step %0d: out=%b expected %b", k, out_b, exp_b);
      end
      if (out_a !== exp_a) begin
        bad++;
        $display("FAIL random_a step %0d: out=%b expected %b", k, out_a, exp_a);
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    areset  = 1'b0;
    in_s    = 1'b0;
    model_b = 1'b1;
    model_a = 1'b0;
    test_reset();
    test_hold();
    test_toggle_hold();
    test_alternate();
    test_mid_reset();
    test_reset_state_a();
    test_random();
    total++;
    if (exp_q_b.size() != 0 || exp_q_a.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d/%0d expected 0/0", exp_q_b.size(), exp_q_a.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
